sir_checker: RTL and testbench

Receive-side checker for the 8-bit sequence stream (`sir`) that the sequence generator emits. It samples the stream whenever the enable is high and learns the arithmetic step from the first two samples. It then verifies every later sample against `prev + step` (mod 2^W) and reports per-sample match/error pulses, lock status and saturating statistics. It sits beside the generator in `top`, driven from the same clock and reset, and gives the bench a self-checking endpoint for the generator output.

---
 rtl/sir_pkg.sv | 22 ++
 rtl/sir_checker_sat_counter.sv | 48 ++++
 rtl/sir_checker.sv | 150 +++++++++++++++
 tb/tb_sir_checker.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sir_pkg.sv
// -----------------------------------------------------------------------------
// sir_pkg
// Shared definitions for the sequence generator and the receive-side checker:
// default sample width, default statistics-counter width and the checker
// state encoding.
// -----------------------------------------------------------------------------
package sir_pkg;

   // Default width of the sir stream; generator and checker must agree.
   localparam int SIR_W     = 8;
   // Default width of the saturating statistics counters.
   localparam int SIR_CNT_W = 16;

   // Checker states: waiting for the first sample, waiting for the second
   // sample (step not yet known), and actively checking.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      LOCKED = 2'd2
   } sir_state_e;

endpackage : sir_pkg

// File: rtl/sir_checker_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, dominates inc
//   inc   : count one event this cycle
//   count : registered count, saturating at 2^CNT_W-1
// -----------------------------------------------------------------------------
module sat_counter
   import sir_pkg::*;
#(
   parameter int CNT_W = SIR_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: add one unless already saturated.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= CNT_ZERO;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : sat_counter

// File: rtl/sir_checker.sv
// -----------------------------------------------------------------------------
// sir_checker
// Receive-side checker for an arithmetic sequence stream. Learns the step from
// the first two consumed samples, then verifies each later sample against
// prev + step (mod 2^W). After MAX_ERR consecutive mismatches it relearns the
// step, using the offending sample as the new base.
//   clk_chk    : rising-edge clock
//   reset_chk  : synchronous active-high reset, dominates en_chk
//   en_chk     : sir_in is consumed on every rising edge where this is high
//   sir_in     : sample from the generator
//   locked     : step is known and checking is active
//   match      : one-cycle pulse, last consumed sample was as expected
//   err        : one-cycle pulse, last consumed sample mismatched
//   step_out   : learned step, meaningful while locked
//   sample_cnt : consumed samples, saturating
//   err_cnt    : mismatches, saturating
// All outputs are registered.
// -----------------------------------------------------------------------------
module sir_checker
   import sir_pkg::*;
#(
   parameter int W       = SIR_W,
   parameter int MAX_ERR = 3,
   parameter int CNT_W   = SIR_CNT_W
) (
   input  logic             clk_chk,
   input  logic             reset_chk,
   input  logic             en_chk,
   input  logic [W-1:0]     sir_in,
   output logic             locked,
   output logic             match,
   output logic             err,
   output logic [W-1:0]     step_out,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   // bad_run only has to reach MAX_ERR, which is at most 15.
   localparam logic [3:0]   MAX_ERR_C = 4'(MAX_ERR);
   localparam logic [W-1:0] W_ZERO    = {W{1'b0}};

   sir_state_e state_q, state_d;
   logic [W-1:0] prev_q, prev_d;
   logic [W-1:0] step_q, step_d;
   logic [3:0]   bad_run_q, bad_run_d;
   logic         match_q, match_d;
   logic         err_q, err_d;
   logic         locked_q, locked_d;

   logic [W-1:0] exp_s;
   logic [3:0]   bad_run_inc_s;

   assign exp_s         = prev_q + step_q;
   assign bad_run_inc_s = bad_run_q + 4'd1;

   // Next-state and next-output logic of the checking FSM.
   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      step_d    = step_q;
      bad_run_d = bad_run_q;
      match_d   = 1'b0;
      err_d     = 1'b0;

      if (en_chk) begin
         case (state_q)
            IDLE: begin
               prev_d  = sir_in;
               state_d = FIRST;
            end
            FIRST: begin
               step_d  = sir_in - prev_q;
               prev_d  = sir_in;
               state_d = LOCKED;
            end
            LOCKED: begin
               if (sir_in == exp_s) begin
                  match_d   = 1'b1;
                  prev_d    = sir_in;
                  bad_run_d = 4'd0;
               end else begin
                  err_d = 1'b1;
                  if (bad_run_inc_s == MAX_ERR_C) begin
                     // Too many in a row: the stream has moved, so take this
                     // sample as the new base and relearn the step.
                     state_d   = FIRST;
                     prev_d    = sir_in;
                     bad_run_d = 4'd0;
                  end else begin
                     // Advance along the expected track so one glitch costs
                     // exactly one error.
                     prev_d    = exp_s;
                     bad_run_d = bad_run_inc_s;
                  end
               end
            end
            default: begin
               state_d   = IDLE;
               prev_d    = W_ZERO;
               bad_run_d = 4'd0;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      locked_d = (state_d == LOCKED);
   end

   // State, datapath and registered-output flops with synchronous reset.
   always_ff @(posedge clk_chk) begin
      if (reset_chk) begin
         state_q   <= IDLE;
         prev_q    <= W_ZERO;
         step_q    <= W_ZERO;
         bad_run_q <= 4'd0;
         match_q   <= 1'b0;
         err_q     <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         step_q    <= step_d;
         bad_run_q <= bad_run_d;
         match_q   <= match_d;
         err_q     <= err_d;
         locked_q  <= locked_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
      .clk   (clk_chk),
      .reset (reset_chk),
      .inc   (en_chk),
      .count (sample_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk_chk),
      .reset (reset_chk),
      .inc   (err_d),
      .count (err_cnt)
   );

   assign locked   = locked_q;
   assign match    = match_q;
   assign err      = err_q;
   assign step_out = step_q;

endmodule : sir_checker

// File: tb/tb_sir_checker.sv
// -----------------------------------------------------------------------------
// tb_sir_checker
// Directed, table-driven bench for sir_checker. The main instance (defaults)
// runs the vector table; a second instance with CNT_W=4, MAX_ERR=15 covers
// counter saturation.
// -----------------------------------------------------------------------------
module tb_sir_checker;

   logic        clk;
   logic        rst0, en0;
   logic [7:0]  sir0;
   logic        locked0, match0, err0;
   logic [7:0]  step0;
   logic [15:0] scnt0, ecnt0;

   logic        rst1, en1;
   logic [7:0]  sir1;
   logic        locked1, match1, err1;
   logic [7:0]  step1;
   logic [3:0]  scnt1, ecnt1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        rst;
      logic        en;
      logic [7:0]  sir;
      logic        locked;
      logic        match;
      logic        err;
      logic        chk_step;
      logic [7:0]  step;
      logic [15:0] scnt;
      logic [15:0] ecnt;
   } vec_t;

   vec_t vecs[$];

   sir_checker #(.W(8), .MAX_ERR(3), .CNT_W(16)) dut0 (
      .clk_chk    (clk),
      .reset_chk  (rst0),
      .en_chk     (en0),
      .sir_in     (sir0),
      .locked     (locked0),
      .match      (match0),
      .err        (err0),
      .step_out   (step0),
      .sample_cnt (scnt0),
      .err_cnt    (ecnt0)
   );

   sir_checker #(.W(8), .MAX_ERR(15), .CNT_W(4)) dut1 (
      .clk_chk    (clk),
      .reset_chk  (rst1),
      .en_chk     (en1),
      .sir_in     (sir1),
      .locked     (locked1),
      .match      (match1),
      .err        (err1),
      .step_out   (step1),
      .sample_cnt (scnt1),
      .err_cnt    (ecnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, idx, act, expv);
      end
   endtask

   function automatic void add(input logic rst, input logic en, input logic [7:0] sir,
                               input logic lk, input logic m, input logic e,
                               input logic cs, input logic [7:0] st,
                               input logic [15:0] sc, input logic [15:0] ec);
      vec_t v;
      v.rst = rst; v.en = en; v.sir = sir;
      v.locked = lk; v.match = m; v.err = e;
      v.chk_step = cs; v.step = st; v.scnt = sc; v.ecnt = ec;
      vecs.push_back(v);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_s, exp_e;
      rst0 = 1'b1; en0 = 1'b0; sir0 = 8'd0;
      rst1 = 1'b1; en1 = 1'b0; sir1 = 8'd0;

      // rst en sir | locked match err chk_step step scnt ecnt
      // Clean ramp, step 5
      add(1, 0, 8'd0,    0, 0, 0, 1, 8'd0,  16'd0, 16'd0);
      add(1, 0, 8'd0,    0, 0, 0, 1, 8'd0,  16'd0, 16'd0);
      add(0, 1, 8'd3,    0, 0, 0, 0, 8'd0,  16'd1, 16'd0);
      add(0, 1, 8'd8,    1, 0, 0, 1, 8'd5,  16'd2, 16'd0);
      add(0, 1, 8'd13,   1, 1, 0, 1, 8'd5,  16'd3, 16'd0);
      add(0, 1, 8'd18,   1, 1, 0, 1, 8'd5,  16'd4, 16'd0);
      add(0, 1, 8'd23,   1, 1, 0, 1, 8'd5,  16'd5, 16'd0);
      add(1, 1, 8'd77,   0, 0, 0, 1, 8'd0,  16'd0, 16'd0);
      // Wrap-around, step 10
      add(0, 1, 8'd240,  0, 0, 0, 0, 8'd0,  16'd1, 16'd0);
      add(0, 1, 8'd250,  1, 0, 0, 1, 8'd10, 16'd2, 16'd0);
      add(0, 1, 8'd4,    1, 1, 0, 1, 8'd10, 16'd3, 16'd0);
      add(0, 1, 8'd14,   1, 1, 0, 1, 8'd10, 16'd4, 16'd0);
      add(1, 0, 8'd0,    0, 0, 0, 1, 8'd0,  16'd0, 16'd0);
      // Negative step: 10 then 7 gives 253
      add(0, 1, 8'd10,   0, 0, 0, 0, 8'd0,  16'd1, 16'd0);
      add(0, 1, 8'd7,    1, 0, 0, 1, 8'd253,16'd2, 16'd0);
      add(0, 1, 8'd4,    1, 1, 0, 1, 8'd253,16'd3, 16'd0);
      add(1, 0, 8'd0,    0, 0, 0, 1, 8'd0,  16'd0, 16'd0);
      // Single glitch on step-1 stream
      add(0, 1, 8'd0,    0, 0, 0, 0, 8'd0,  16'd1, 16'd0);
      add(0, 1, 8'd1,    1, 0, 0, 1, 8'd1,  16'd2, 16'd0);
      add(0, 1, 8'd2,    1, 1, 0, 1, 8'd1,  16'd3, 16'd0);
      add(0, 1, 8'd99,   1, 0, 1, 1, 8'd1,  16'd4, 16'd1);
      add(0, 1, 8'd4,    1, 1, 0, 1, 8'd1,  16'd5, 16'd1);
      add(0, 1, 8'd5,    1, 1, 0, 1, 8'd1,  16'd6, 16'd1);
      add(1, 0, 8'd0,    0, 0, 0, 1, 8'd0,  16'd0, 16'd0);
      // Relock after three consecutive errors
      add(0, 1, 8'd0,    0, 0, 0, 0, 8'd0,  16'd1, 16'd0);
      add(0, 1, 8'd2,    1, 0, 0, 1, 8'd2,  16'd2, 16'd0);
      add(0, 1, 8'd4,    1, 1, 0, 1, 8'd2,  16'd3, 16'd0);
      add(0, 1, 8'd50,   1, 0, 1, 1, 8'd2,  16'd4, 16'd1);
      add(0, 1, 8'd60,   1, 0, 1, 1, 8'd2,  16'd5, 16'd2);
      add(0, 1, 8'd70,   0, 0, 1, 0, 8'd0,  16'd6, 16'd3);
      add(0, 1, 8'd80,   1, 0, 0, 1, 8'd10, 16'd7, 16'd3);
      add(0, 1, 8'd90,   1, 1, 0, 1, 8'd10, 16'd8, 16'd3);
      add(1, 0, 8'd0,    0, 0, 0, 1, 8'd0,  16'd0, 16'd0);
      // Enable gaps
      add(0, 1, 8'd1,    0, 0, 0, 0, 8'd0,  16'd1, 16'd0);
      for (int g = 0; g < 4; g++) add(0, 0, 8'hAA, 0, 0, 0, 0, 8'd0, 16'd1, 16'd0);
      add(0, 1, 8'd2,    1, 0, 0, 1, 8'd1,  16'd2, 16'd0);
      for (int g = 0; g < 4; g++) add(0, 0, 8'h55, 1, 0, 0, 1, 8'd1, 16'd2, 16'd0);
      add(0, 1, 8'd3,    1, 1, 0, 1, 8'd1,  16'd3, 16'd0);
      for (int g = 0; g < 4; g++) add(0, 0, 8'hAA, 1, 0, 0, 1, 8'd1, 16'd3, 16'd0);
      // Reset mid-stream with en high, then relearn
      add(1, 1, 8'd4,    0, 0, 0, 1, 8'd0,  16'd0, 16'd0);
      add(0, 1, 8'd4,    0, 0, 0, 0, 8'd0,  16'd1, 16'd0);
      add(0, 1, 8'd5,    1, 0, 0, 1, 8'd1,  16'd2, 16'd0);
      add(0, 1, 8'd6,    1, 1, 0, 1, 8'd1,  16'd3, 16'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst0 = vecs[i].rst;
         en0  = vecs[i].en;
         sir0 = vecs[i].sir;
         cyc();
         chk("locked", i, int'(locked0), int'(vecs[i].locked));
         chk("match",  i, int'(match0),  int'(vecs[i].match));
         chk("err",    i, int'(err0),    int'(vecs[i].err));
         chk("sample_cnt", i, int'(scnt0), int'(vecs[i].scnt));
         chk("err_cnt",    i, int'(ecnt0), int'(vecs[i].ecnt));
         if (vecs[i].chk_step) chk("step_out", i, int'(step0), int'(vecs[i].step));
      end
      en0 = 1'b0;

      // Saturation: 4-bit counters, MAX_ERR=15, stream i*i (post-lock wrong)
      rst1 = 1'b1; en1 = 1'b0;
      cyc();
      chk("sat_reset_scnt", 0, int'(scnt1), 0);
      chk("sat_reset_ecnt", 0, int'(ecnt1), 0);
      rst1 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         en1  = 1'b1;
         sir1 = 8'((i * i) & 255);
         cyc();
         exp_s = (i + 1 > 15) ? 15 : i + 1;
         exp_e = (i < 2) ? 0 : ((i - 1 > 15) ? 15 : i - 1);
         chk("sat_scnt", i, int'(scnt1), exp_s);
         chk("sat_ecnt", i, int'(ecnt1), exp_e);
         if (i == 16) chk("sat_relock_locked", i, int'(locked1), 0);
         if (i == 19) chk("sat_err_pulse", i, int'(err1), 1);
      end
      en1 = 1'b0;
      cyc();
      chk("sat_hold_scnt", 20, int'(scnt1), 15);
      chk("sat_hold_ecnt", 20, int'(ecnt1), 15);
      chk("sat_no_pulse",  20, int'(err1), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sir_checker
